fetch_pc_gen: RTL and testbench

Program-counter generator for the RISC-V core, directly upstream of `fetch_instruction`. It owns the architectural fetch PC, chooses between sequential (PC+4) and redirected (branch/jump target) flow, and holds the PC on pipeline stalls. Alongside each instruction that emerges from the BIOS/IMEM read, it produces the matching `fetch_pc`, the `inst_sel` memory-select and the `is_j_or_b` kill flag, all aligned to the one-cycle memory latency.

---
 rtl/fetch_pc_gen.sv | 85 ++++++++
 tb/tb_fetch_pc_gen.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/fetch_pc_gen.sv
// Fetch PC generator: sequential/redirect next-PC selection, stall hold,
// and fetch_pc/inst_sel/kill outputs aligned to one-cycle memory latency.
module fetch_pc_gen #(
  parameter logic [31:0] RESET_PC    = 32'h4000_0000,
  parameter logic [3:0]  BIOS_REGION = 4'h4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_target,
  output logic [31:0] pc,
  output logic [31:0] fetch_pc,
  output logic        inst_sel,
  output logic        is_j_or_b,
  output logic        fetch_valid,
  output logic        misaligned
);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    KILL = 2'd2
  } state_t;

  state_t      state_q;
  state_t      state_d;
  logic        hold;
  logic [31:0] pc_d;
  logic        kill_d;
  logic        valid_d;
  logic        mis_d;

  // A redirect overrides a stall; only a plain stall freezes fetch.
  assign hold = stall && !redirect;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= BOOT;
    end else if (!hold) begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      BOOT:    state_d = redirect ? KILL : RUN;
      RUN:     state_d = redirect ? KILL : RUN;
      KILL:    state_d = redirect ? KILL : RUN;
      default: state_d = BOOT;
    endcase
  end

  always_comb begin
    kill_d  = (state_d != RUN);
    valid_d = (state_d == RUN);
    mis_d   = redirect && (redirect_target[1:0] != 2'b00);
    pc_d    = pc + 32'd4;
    if (redirect) begin
      pc_d = {redirect_target[31:2], 2'b00};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc          <= RESET_PC;
      fetch_pc    <= RESET_PC;
      inst_sel    <= (RESET_PC[31:28] == BIOS_REGION);
      is_j_or_b   <= 1'b1;
      fetch_valid <= 1'b0;
      misaligned  <= 1'b0;
    end else if (hold) begin
      misaligned  <= 1'b0;
    end else begin
      pc          <= pc_d;
      fetch_pc    <= pc;
      inst_sel    <= (pc[31:28] == BIOS_REGION);
      is_j_or_b   <= kill_d;
      fetch_valid <= valid_d;
      misaligned  <= mis_d;
    end
  end

endmodule

// File: tb/tb_fetch_pc_gen.sv
// Directed bench for fetch_pc_gen with immediate-assertion checks.
module tb_fetch_pc_gen;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_target;
  logic [31:0] pc;
  logic [31:0] fetch_pc;
  logic        inst_sel;
  logic        is_j_or_b;
  logic        fetch_valid;
  logic        misaligned;

  int compared;
  int mismatched;

  fetch_pc_gen dut (
    .clk             (clk),
    .rst             (rst),
    .stall           (stall),
    .redirect        (redirect),
    .redirect_target (redirect_target),
    .pc              (pc),
    .fetch_pc        (fetch_pc),
    .inst_sel        (inst_sel),
    .is_j_or_b       (is_j_or_b),
    .fetch_valid     (fetch_valid),
    .misaligned      (misaligned)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [31:0] e_pc,
                         input logic [31:0] e_fpc, input logic e_sel,
                         input logic e_kill, input logic e_val,
                         input logic e_mis);
    chk({tag, ".pc"}, pc, e_pc);
    chk({tag, ".fetch_pc"}, fetch_pc, e_fpc);
    chk({tag, ".inst_sel"}, {31'd0, inst_sel}, {31'd0, e_sel});
    chk({tag, ".kill"}, {31'd0, is_j_or_b}, {31'd0, e_kill});
    chk({tag, ".valid"}, {31'd0, fetch_valid}, {31'd0, e_val});
    chk({tag, ".mis"}, {31'd0, misaligned}, {31'd0, e_mis});
  endtask

  initial begin
    compared        = 0;
    mismatched      = 0;
    rst             = 1'b1;
    stall           = 1'b0;
    redirect        = 1'b0;
    redirect_target = 32'h0;
    step();
    step();
    chk_all("reset", 32'h4000_0000, 32'h4000_0000, 1, 1, 0, 0);

    // boot sequence
    rst = 1'b0;
    step();
    chk_all("run0", 32'h4000_0004, 32'h4000_0000, 1, 0, 1, 0);
    step();
    chk_all("run1", 32'h4000_0008, 32'h4000_0004, 1, 0, 1, 0);
    step();
    step();
    chk("pc_10", pc, 32'h4000_0010);

    // redirect to IMEM
    redirect        = 1'b1;
    redirect_target = 32'h1000_0020;
    step();
    chk_all("redir_k", 32'h1000_0020, 32'h4000_0010, 1, 1, 0, 0);
    redirect = 1'b0;
    step();
    chk_all("redir_v", 32'h1000_0024, 32'h1000_0020, 0, 0, 1, 0);

    // advance to 1000_0040 and stall 3 cycles
    for (int i = 0; i < 7; i++) step();
    chk("pc_40", pc, 32'h1000_0040);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_all("stall", 32'h1000_0040, 32'h1000_003C, 0, 0, 1, 0);
    end
    stall = 1'b0;
    step();
    chk_all("unstall", 32'h1000_0044, 32'h1000_0040, 0, 0, 1, 0);

    // misaligned redirect while stalled
    stall           = 1'b1;
    redirect        = 1'b1;
    redirect_target = 32'h1000_0102;
    step();
    chk_all("st_redir", 32'h1000_0100, 32'h1000_0044, 0, 1, 0, 1);
    stall    = 1'b0;
    redirect = 1'b0;
    step();
    chk_all("st_redir_v", 32'h1000_0104, 32'h1000_0100, 0, 0, 1, 0);

    // back-to-back redirects
    redirect        = 1'b1;
    redirect_target = 32'h1000_0200;
    step();
    chk_all("b2b_a", 32'h1000_0200, 32'h1000_0104, 0, 1, 0, 0);
    redirect_target = 32'h1000_0300;
    step();
    chk_all("b2b_b", 32'h1000_0300, 32'h1000_0200, 0, 1, 0, 0);
    redirect = 1'b0;
    step();
    chk_all("b2b_v", 32'h1000_0304, 32'h1000_0300, 0, 0, 1, 0);

    // wrap around
    redirect        = 1'b1;
    redirect_target = 32'hFFFF_FFFC;
    step();
    chk("wrap_pc", pc, 32'hFFFF_FFFC);
    redirect = 1'b0;
    step();
    chk_all("wrap", 32'h0000_0000, 32'hFFFF_FFFC, 0, 0, 1, 0);
    step();
    chk_all("wrap2", 32'h0000_0004, 32'h0000_0000, 0, 0, 1, 0);

    // reset beats stall and redirect
    stall           = 1'b1;
    redirect        = 1'b1;
    redirect_target = 32'h1000_0000;
    rst             = 1'b1;
    step();
    chk_all("mid_rst", 32'h4000_0000, 32'h4000_0000, 1, 1, 0, 0);

    // misaligned pulse drops under a plain stall; KILL holds
    rst             = 1'b0;
    stall           = 1'b0;
    redirect_target = 32'h1000_0001;
    step();
    chk_all("mis_pulse", 32'h1000_0000, 32'h4000_0000, 1, 1, 0, 1);
    redirect = 1'b0;
    stall    = 1'b1;
    step();
    chk_all("mis_drop", 32'h1000_0000, 32'h4000_0000, 1, 1, 0, 0);
    stall = 1'b0;
    step();
    chk_all("mis_after", 32'h1000_0004, 32'h1000_0000, 0, 0, 1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
